// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared FSM encoding and frame field constants for spi_slave_regs.
package spi_slave_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_e;
  localparam int CMD_RW_BIT = 7;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for one async pin with registered rise/fall strobes.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic block_clk_i,
  input  logic rst_low_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES:0] sync_q;
  logic            rise_q, fall_q;
  // sync_q[STAGES] is the previous level, so strobes land STAGES+1 clocks after the pin edge
  always_ff @(posedge block_clk_i or negedge rst_low_i)
    if (!rst_low_i) begin
      sync_q <= {(STAGES+1){RST_VAL}};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-1:0], pin_i};
      rise_q <= sync_q[STAGES-1] & ~sync_q[STAGES];
      fall_q <= ~sync_q[STAGES-1] & sync_q[STAGES];
    end
  assign level_o = sync_q[STAGES-1];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI mode-0 slave with an NREGS x 8-bit register file, oversampled in block_clk_i.
// Optional write-strobe outputs are enabled by defining SPI_SLAVE_WSTROBE_EN.
module spi_slave_regs
  import spi_slave_pkg::*;
#(
  parameter int          NREGS       = 16,
  parameter int          ADDR_W      = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  RESET_VAL   = 8'h00
) (
  input  logic                 block_clk_i,
  input  logic                 rst_low_i,
  input  logic                 spi_sclk_i,
  input  logic                 spi_ss_i,
  input  logic                 spi_mosi_i,
  output logic                 spi_miso_o,
  output logic [NREGS*8-1:0]   regs_o,
  output logic                 frame_err_o
`ifdef SPI_SLAVE_WSTROBE_EN
  ,
  output logic                 wr_stb_o,
  output logic [ADDR_W-1:0]    wr_addr_o,
  output logic [7:0]           wr_data_o
`endif
);
  localparam logic [7:0] NREGS_B   = 8'(NREGS);
  localparam logic [6:0] ADDR_LAST = 7'(NREGS-1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .block_clk_i(block_clk_i), .rst_low_i(rst_low_i), .pin_i(spi_sclk_i),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .block_clk_i(block_clk_i), .rst_low_i(rst_low_i), .pin_i(spi_ss_i),
    .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .block_clk_i(block_clk_i), .rst_low_i(rst_low_i), .pin_i(spi_mosi_i),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));
  assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

  state_e                state_q;
  logic [2:0]            bit_cnt_q;
  logic [BYTE_W-1:0]     rx_q, tx_q;
  logic [6:0]            addr_q;
  logic                  rw_q, wrap_q, miso_q, err_q;
  logic                  pend_q;
  logic [ADDR_W-1:0]     pend_addr_q;
  logic [BYTE_W-1:0]     pend_data_q;
  logic [NREGS*8-1:0]    regs_q;
  logic [BYTE_W-1:0]     rx_d, rd_cmd, rd_nx;
  logic [6:0]            addr_nx;
  logic                  byte_done;

  function automatic logic in_rng(input logic [6:0] a);
    return {1'b0, a} < NREGS_B;
  endfunction

  function automatic logic [BYTE_W-1:0] rd(input logic [6:0] a);
    return in_rng(a) ? regs_q[{a[ADDR_W-1:0], 3'b000} +: BYTE_W] : '0;
  endfunction

  always_comb begin
    rx_d      = {rx_q[BYTE_W-2:0], mosi_lvl};
    byte_done = (state_q != ST_IDLE) && sclk_rise && (&bit_cnt_q);
    // frames that start in range wrap at NREGS; others count mod 128
    addr_nx   = (wrap_q && addr_q == ADDR_LAST) ? 7'd0 : addr_q + 7'd1;
    rd_cmd    = rd(rx_d[CMD_RW_BIT-1:0]);
    rd_nx     = rd(addr_nx);
  end

  always_ff @(posedge block_clk_i or negedge rst_low_i)
    if (!rst_low_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      wrap_q      <= 1'b0;
      miso_q      <= 1'b0;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      regs_q      <= {NREGS{RESET_VAL}};
    end else begin
      pend_q <= 1'b0;
      if (pend_q) regs_q[{pend_addr_q, 3'b000} +: BYTE_W] <= pend_data_q;
      if (state_q == ST_IDLE) begin
        miso_q    <= 1'b0;
        tx_q      <= '0;
        bit_cnt_q <= '0;
        if (ss_fall) state_q <= ST_CMD;
      end else begin
        if (sclk_rise) begin
          rx_q      <= rx_d;
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        // the fall right after a byte boundary keeps the freshly loaded MSB on MISO
        if (sclk_fall && bit_cnt_q != 3'd0) begin
          tx_q   <= {tx_q[BYTE_W-2:0], 1'b0};
          miso_q <= tx_q[BYTE_W-2];
        end
        if (byte_done) begin
          err_q <= 1'b0;
          if (state_q == ST_CMD) begin
            rw_q    <= rx_d[CMD_RW_BIT];
            addr_q  <= rx_d[CMD_RW_BIT-1:0];
            wrap_q  <= in_rng(rx_d[CMD_RW_BIT-1:0]);
            tx_q    <= rx_d[CMD_RW_BIT] ? rd_cmd : '0;
            miso_q  <= rx_d[CMD_RW_BIT] & rd_cmd[BYTE_W-1];
            state_q <= ST_DATA;
          end else begin
            addr_q <= addr_nx;
            tx_q   <= rw_q ? rd_nx : '0;
            miso_q <= rw_q & rd_nx[BYTE_W-1];
            if (!rw_q && in_rng(addr_q)) begin
              pend_q      <= 1'b1;
              pend_addr_q <= addr_q[ADDR_W-1:0];
              pend_data_q <= rx_d;
            end
          end
        end
        if (ss_rise) begin
          state_q   <= ST_IDLE;
          miso_q    <= 1'b0;
          bit_cnt_q <= '0;
          if (!byte_done && (sclk_rise || bit_cnt_q != 3'd0)) err_q <= 1'b1;
        end
      end
    end

`ifdef SPI_SLAVE_WSTROBE_EN
  logic stb_q;
  always_ff @(posedge block_clk_i or negedge rst_low_i)
    if (!rst_low_i) stb_q <= 1'b0;
    else stb_q <= pend_q;
  assign wr_stb_o  = stb_q;
  assign wr_addr_o = pend_addr_q;
  assign wr_data_o = pend_data_q;
`endif

  assign spi_miso_o  = miso_q & ~ss_lvl;
  assign regs_o      = regs_q;
  assign frame_err_o = err_q;
endmodule

// File: tb/tb_spi_slave_regs.sv
// tb_spi_slave_regs: directed frames from a simple AHBspi-style master model, 50MHz clk / 5MHz SCLK.
module tb_spi_slave_regs;
  logic         clk = 1'b0;
  logic         rst_low = 1'b0;
  logic         sclk = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic         miso, ferr;
  logic [127:0] regs_o, exp_regs;
  logic [7:0]   r;
  int           checks = 0, errors = 0;

  always #10 clk = ~clk;

`ifdef SPI_SLAVE_WSTROBE_EN
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  int         stb_n = 0;
  logic [3:0] stb_a[8];
  logic [7:0] stb_d[8];
  always @(negedge clk) if (wr_stb) begin
    if (stb_n < 8) begin stb_a[stb_n] = wr_addr; stb_d[stb_n] = wr_data; end
    stb_n++;
  end
`endif

  spi_slave_regs dut (
    .block_clk_i(clk), .rst_low_i(rst_low), .spi_sclk_i(sclk), .spi_ss_i(ss),
    .spi_mosi_i(mosi), .spi_miso_o(miso), .regs_o(regs_o), .frame_err_o(ferr)
`ifdef SPI_SLAVE_WSTROBE_EN
    , .wr_stb_o(wr_stb), .wr_addr_o(wr_addr), .wr_data_o(wr_data)
`endif
  );

  task automatic xfer(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      #100 sclk = 1'b1;
      rx = {rx[6:0], miso};
      #100 sclk = 1'b0;
    end
  endtask

  task automatic ss_begin();
    ss = 1'b0;
    #100;
  endtask

  task automatic ss_end();
    #100 ss = 1'b1;
    #200;
  endtask

  task automatic test_reset();
    exp_regs = '0;
    #50;
    checks++; if (regs_o !== exp_regs) begin errors++; $display("FAIL reset_regs got %h exp %h", regs_o, exp_regs); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", miso); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", ferr); end
    #50 rst_low = 1'b1;
    #200;
  endtask

  task automatic test_write();
`ifdef SPI_SLAVE_WSTROBE_EN
    int n0 = stb_n;
`endif
    ss_begin(); xfer(8'h01, 8, r); xfer(8'h08, 8, r); ss_end();
    exp_regs[15:8] = 8'h08;
    checks++; if (regs_o !== exp_regs) begin errors++; $display("FAIL write_regs got %h exp %h", regs_o, exp_regs); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL write_err got %b exp 0", ferr); end
`ifdef SPI_SLAVE_WSTROBE_EN
    checks++; if (stb_n - n0 != 1 || stb_a[n0] !== 4'd1 || stb_d[n0] !== 8'h08) begin errors++; $display("FAIL write_stb got n=%0d a=%h d=%h exp n=1 a=1 d=08", stb_n - n0, stb_a[n0], stb_d[n0]); end
`endif
  endtask

  task automatic test_read();
    logic [7:0] r0;
    ss_begin(); xfer(8'h81, 8, r0); xfer(8'h00, 8, r); ss_end();
    checks++; if (r0 !== 8'h00) begin errors++; $display("FAIL read_cmd_miso got %h exp 00", r0); end
    checks++; if (r !== 8'h08) begin errors++; $display("FAIL read_data got %h exp 08", r); end
    checks++; if (regs_o !== exp_regs) begin errors++; $display("FAIL read_regs got %h exp %h", regs_o, exp_regs); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL read_miso_idle got %b exp 0", miso); end
  endtask

  task automatic test_burst_wrap();
`ifdef SPI_SLAVE_WSTROBE_EN
    int n0 = stb_n;
`endif
    ss_begin(); xfer(8'h0F, 8, r); xfer(8'h11, 8, r); xfer(8'h22, 8, r); ss_end();
    exp_regs[127:120] = 8'h11;
    exp_regs[7:0]     = 8'h22;
    checks++; if (regs_o !== exp_regs) begin errors++; $display("FAIL burst_regs got %h exp %h", regs_o, exp_regs); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL burst_err got %b exp 0", ferr); end
`ifdef SPI_SLAVE_WSTROBE_EN
    checks++; if (stb_n - n0 != 2) begin errors++; $display("FAIL burst_stb_count got %0d exp 2", stb_n - n0); end
    checks++; if (stb_a[n0] !== 4'd15 || stb_d[n0] !== 8'h11) begin errors++; $display("FAIL burst_stb0 got a=%h d=%h exp a=f d=11", stb_a[n0], stb_d[n0]); end
    checks++; if (stb_a[n0+1] !== 4'd0 || stb_d[n0+1] !== 8'h22) begin errors++; $display("FAIL burst_stb1 got a=%h d=%h exp a=0 d=22", stb_a[n0+1], stb_d[n0+1]); end
`endif
  endtask

  task automatic test_abort();
    ss_begin(); xfer(8'h03, 8, r); xfer(8'hFF, 5, r); ss_end();
    checks++; if (ferr !== 1'b1) begin errors++; $display("FAIL abort_err got %b exp 1", ferr); end
    checks++; if (regs_o !== exp_regs) begin errors++; $display("FAIL abort_regs got %h exp %h", regs_o, exp_regs); end
    ss_begin(); xfer(8'h04, 8, r);
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL abort_clear got %b exp 0", ferr); end
    xfer(8'h3C, 8, r); ss_end();
    exp_regs[39:32] = 8'h3C;
    checks++; if (regs_o !== exp_regs) begin errors++; $display("FAIL abort_next_regs got %h exp %h", regs_o, exp_regs); end
  endtask

  task automatic test_out_of_range();
    logic [7:0] r2;
`ifdef SPI_SLAVE_WSTROBE_EN
    int n0;
`endif
    ss_begin(); xfer(8'hFF, 8, r); xfer(8'h00, 8, r); xfer(8'h00, 8, r2); ss_end();
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL oor_read got %h exp 00", r); end
    checks++; if (r2 !== 8'h22) begin errors++; $display("FAIL oor_wrap_read got %h exp 22", r2); end
`ifdef SPI_SLAVE_WSTROBE_EN
    n0 = stb_n;
`endif
    ss_begin(); xfer(8'h7F, 8, r); xfer(8'h55, 8, r); ss_end();
    checks++; if (regs_o !== exp_regs) begin errors++; $display("FAIL oor_write_regs got %h exp %h", regs_o, exp_regs); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL oor_err got %b exp 0", ferr); end
`ifdef SPI_SLAVE_WSTROBE_EN
    checks++; if (stb_n != n0) begin errors++; $display("FAIL oor_stb got %0d exp 0", stb_n - n0); end
`endif
  endtask

  task automatic test_simultaneous_end();
    ss_begin(); xfer(8'h05, 8, r); xfer(8'h5A, 7, r);
    mosi = 1'b0;
    #100 sclk = 1'b1; ss = 1'b1;
    #100 sclk = 1'b0;
    #200;
    exp_regs[47:40] = 8'h5A;
    checks++; if (regs_o !== exp_regs) begin errors++; $display("FAIL simul_regs got %h exp %h", regs_o, exp_regs); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL simul_err got %b exp 0", ferr); end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 8; i++) begin
      mosi = 1'b1;
      #100 sclk = 1'b1;
      #100 sclk = 1'b0;
    end
    #200;
    checks++; if (regs_o !== exp_regs) begin errors++; $display("FAIL glitch_regs got %h exp %h", regs_o, exp_regs); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL glitch_err got %b exp 0", ferr); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL glitch_miso got %b exp 0", miso); end
  endtask

  task automatic test_reset_mid();
    ss_begin(); xfer(8'h81, 8, r); xfer(8'h00, 4, r);
    #120;
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL mid_miso_pre got %b exp 1", miso); end
    rst_low = 1'b0;
    #1;
    exp_regs = '0;
    checks++; if (regs_o !== exp_regs) begin errors++; $display("FAIL mid_reset_regs got %h exp %h", regs_o, exp_regs); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL mid_reset_miso got %b exp 0", miso); end
    ss = 1'b1; sclk = 1'b0;
    #99 rst_low = 1'b1;
    #200;
    ss_begin(); xfer(8'h02, 8, r); xfer(8'hA5, 8, r); ss_end();
    exp_regs[23:16] = 8'hA5;
    checks++; if (regs_o !== exp_regs) begin errors++; $display("FAIL mid_next_regs got %h exp %h", regs_o, exp_regs); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL mid_next_err got %b exp 0", ferr); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_burst_wrap();
    test_abort();
    test_out_of_range();
    test_simultaneous_end();
    test_glitch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
